// File: rtl/wb_retire_multi.sv
// rtl/wb_retire_multi.sv - multi-lane writeback/retire stage with bundle FIFO
//
// Purpose: accepts MEM-stage bundles of up to LANES results over valid/ready,
// buffers them in a DEPTH-entry bundle FIFO and drives LANES register-file
// write ports. Handles in-bundle WAW, x0 suppression, sticky halt, flush and
// counts retired lanes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 discard buffered and incoming bundles this cycle
//   in_valid / in_ready   bundle handshake from MEM
//   in_lane_vld, in_memtoreg, in_regwr, in_done   per-lane control bits
//   in_rd, in_do, in_alu, in_pc                   per-lane packed fields
//   out_ready             commit side accepts a bundle
//   rf_we, rf_rw, rf_di   register-file write ports (we is a pulse)
//   wb, pc_o              commit trace of retired lanes
//   done_o, halted        halt pulse and sticky halt flag
//   retire_cnt            running count of retired lanes (wraps)
module wb_retire_multi #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_vld,
    input  logic [LANES-1:0]        in_memtoreg,
    input  logic [LANES-1:0]        in_regwr,
    input  logic [LANES-1:0]        in_done,
    input  logic [5*LANES-1:0]      in_rd,
    input  logic [DATA_W*LANES-1:0] in_do,
    input  logic [DATA_W*LANES-1:0] in_alu,
    input  logic [DATA_W*LANES-1:0] in_pc,
    input  logic                    out_ready,
    output logic [LANES-1:0]        rf_we,
    output logic [5*LANES-1:0]      rf_rw,
    output logic [DATA_W*LANES-1:0] rf_di,
    output logic [LANES-1:0]        wb,
    output logic [DATA_W*LANES-1:0] pc_o,
    output logic                    done_o,
    output logic                    halted,
    output logic [CNT_W-1:0]        retire_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LANES + 1);

    // Bundle storage; the data mux is applied before the write so only one
    // data word per lane is kept.
    logic [LANES-1:0]        mem_vld   [DEPTH];
    logic [LANES-1:0]        mem_regwr [DEPTH];
    logic [LANES-1:0]        mem_done  [DEPTH];
    logic [5*LANES-1:0]      mem_rd    [DEPTH];
    logic [DATA_W*LANES-1:0] mem_data  [DEPTH];
    logic [DATA_W*LANES-1:0] mem_pc    [DEPTH];

    logic [AW:0] wptr_q, rptr_q;
    logic        full, empty, push, pop;

    logic [LANES-1:0]        rf_we_q, wb_q;
    logic [5*LANES-1:0]      rf_rw_q;
    logic [DATA_W*LANES-1:0] rf_di_q, pc_q;
    logic                    done_q, halted_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [DATA_W*LANES-1:0] din_data;
    logic [LANES-1:0]        h_vld, h_regwr, h_done;
    logic [5*LANES-1:0]      h_rd;
    logic [LANES-1:0]        killed, overwritten, wb_d, rf_we_d;
    logic                    seen_done, any_done;
    logic [CW-1:0]           pop_cnt;

    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty    = (wptr_q == rptr_q);
    assign in_ready = !full && !halted_q && rst_n;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !empty && out_ready && !flush && !halted_q;

    always_comb begin
        din_data = '0;
        for (int i = 0; i < LANES; i++) begin
            din_data[i*DATA_W +: DATA_W] = in_memtoreg[i] ? in_do[i*DATA_W +: DATA_W]
                                                          : in_alu[i*DATA_W +: DATA_W];
        end
    end

    assign h_vld   = mem_vld[rptr_q[AW-1:0]];
    assign h_regwr = mem_regwr[rptr_q[AW-1:0]];
    assign h_done  = mem_done[rptr_q[AW-1:0]];
    assign h_rd    = mem_rd[rptr_q[AW-1:0]];

    // Lane qualification for the head bundle: lanes behind a done lane are
    // killed; a lower lane's write is dropped when a higher retiring lane
    // writes the same register.
    always_comb begin
        killed      = '0;
        overwritten = '0;
        wb_d        = '0;
        rf_we_d     = '0;
        seen_done   = 1'b0;
        pop_cnt     = '0;
        for (int i = 0; i < LANES; i++) begin
            killed[i] = seen_done;
            seen_done = seen_done | (h_vld[i] & h_done[i]);
        end
        wb_d = h_vld & ~killed;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (j > i && wb_d[j] && h_regwr[j] && (h_rd[j*5 +: 5] == h_rd[i*5 +: 5])) begin
                    overwritten[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            rf_we_d[i] = wb_d[i] && h_regwr[i] && !h_done[i] &&
                         (h_rd[i*5 +: 5] != 5'd0) && !overwritten[i];
            pop_cnt    = pop_cnt + CW'(wb_d[i]);
        end
    end

    assign any_done = |(wb_d & h_done);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_vld[wptr_q[AW-1:0]]   <= in_lane_vld;
            mem_regwr[wptr_q[AW-1:0]] <= in_regwr;
            mem_done[wptr_q[AW-1:0]]  <= in_done;
            mem_rd[wptr_q[AW-1:0]]    <= in_rd;
            mem_data[wptr_q[AW-1:0]]  <= din_data;
            mem_pc[wptr_q[AW-1:0]]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rf_we_q  <= '0;
            wb_q     <= '0;
            rf_rw_q  <= '0;
            rf_di_q  <= '0;
            pc_q     <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rf_we_q <= '0;
            wb_q    <= '0;
            done_q  <= 1'b0;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (pop) begin
                    rf_we_q <= rf_we_d;
                    wb_q    <= wb_d;
                    done_q  <= any_done;
                    rf_rw_q <= h_rd;
                    rf_di_q <= mem_data[rptr_q[AW-1:0]];
                    pc_q    <= mem_pc[rptr_q[AW-1:0]];
                    cnt_q   <= cnt_q + CNT_W'(pop_cnt);
                end
                // Retiring a done lane halts and drops everything still queued,
                // including a bundle pushed on the same edge.
                if (pop && any_done) begin
                    halted_q <= 1'b1;
                    wptr_q   <= '0;
                    rptr_q   <= '0;
                end else begin
                    if (pop)  rptr_q <= rptr_q + 1'b1;
                    if (push) wptr_q <= wptr_q + 1'b1;
                end
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign wb         = wb_q;
    assign rf_rw      = rf_rw_q;
    assign rf_di      = rf_di_q;
    assign pc_o       = pc_q;
    assign done_o     = done_q;
    assign halted     = halted_q;
    assign retire_cnt = cnt_q;

endmodule
